// File: rtl/mmio_interconnect.sv
// mmio_interconnect: table-decoded MMIO bridge from one master to NUM_SLAVES slaves with wait states, unmapped error and optional timeout (MMIO_TIMEOUT_EN).
// Ports: clock/reset (sync, active-high); m_req/m_we/m_addr/m_wdata in and m_rdata/m_ready/m_err out on the master side;
// s_sel/s_we/s_addr/s_wdata out and s_rdata/s_ready in on the shared slave side.
module mmio_interconnect #(
    parameter int WIDTH = 32,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*WIDTH-1:0] SLAVE_BASE = {32'h0000_0500, 32'h0000_0000},
    parameter logic [NUM_SLAVES*8-1:0] SLAVE_SPAN_LOG2 = {8'd2, 8'd16},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        m_req,
    input  logic                        m_we,
    input  logic [WIDTH-1:0]            m_addr,
    input  logic [WIDTH-1:0]            m_wdata,
    output logic [WIDTH-1:0]            m_rdata,
    output logic                        m_ready,
    output logic                        m_err,
    output logic [NUM_SLAVES-1:0]       s_sel,
    output logic                        s_we,
    output logic [WIDTH-1:0]            s_addr,
    output logic [WIDTH-1:0]            s_wdata,
    input  logic [NUM_SLAVES*WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]       s_ready
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
    logic [1:0] state_q, state_d;
    logic [NUM_SLAVES-1:0] hit, hit_q, hit_d;
    logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sel_rdata;
    logic we_q, we_d, err_q, err_d, ack, timeout;
    // Later slots overwrite earlier ones, so the highest matching index wins on overlap.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (((m_addr ^ SLAVE_BASE[i*WIDTH +: WIDTH]) >> SLAVE_SPAN_LOG2[i*8 +: 8]) == '0) begin
                hit = '0;
                hit[i] = 1'b1;
            end
    end
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (hit_q[i]) sel_rdata = s_rdata[i*WIDTH +: WIDTH];
    end
    assign ack = |(hit_q & s_ready);
`ifdef MMIO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Held at zero outside ACCESS, so it is clear on every entry.
    assign cnt_d = state_q == ACCESS ? cnt_q + CW'(1) : '0;
    assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        hit_d = hit_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        we_d = we_q;
        rdata_d = rdata_q;
        err_d = err_q;
        if (state_q == IDLE && m_req) begin
            addr_d = m_addr;
            wdata_d = m_wdata;
            we_d = m_we;
            hit_d = hit;
            err_d = ~|hit;
            rdata_d = |hit ? rdata_q : '0;
            state_d = |hit ? ACCESS : RESP;
        end else if (state_q == ACCESS) begin
            // A slave answer in the limit cycle still completes successfully.
            if (ack) begin
                rdata_d = we_q ? '0 : sel_rdata;
                err_d = 1'b0;
                state_d = RESP;
            end else if (timeout) begin
                rdata_d = '0;
                err_d = 1'b1;
                state_d = RESP;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            hit_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            we_q <= 1'b0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q <= hit_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            we_q <= we_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
        end
    end
    assign m_ready = state_q == RESP;
    assign m_err = m_ready & err_q;
    assign m_rdata = rdata_q;
    assign s_sel = state_q == ACCESS ? hit_q : '0;
    assign s_we = (state_q == ACCESS) & we_q;
    assign s_addr = addr_q;
    assign s_wdata = wdata_q;
endmodule
